// File: rtl/stdp_update_engine_if.sv
// Weight-RAM port bundle: the STDP engine is the master, the synapse BRAM the slave.
// Read data arrives one cycle after rd_en/rd_addr.
interface stdp_update_engine_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 64
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, input rd_data);
   modport slave  (input rd_en, rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/stdp_update_engine.sv
// STDP weight-update engine: one sweep of the weight RAM per start,
// w' = clamp(w + LTP - LTD - DECAY) per lane, through a 3-stage read-modify-write pipe.
module stdp_update_engine #(
   parameter int N_PRE     = 24,
   parameter int N_POST    = 18,
   parameter int ROWS      = 24,
   parameter int W_BITS    = 16,
   parameter int T_BITS    = 16,
   parameter int W_MIN     = 0,
   parameter int W_MAX     = 65535,
   parameter int SKIP_IDLE = 1,
   parameter int ADDR_W    = $clog2(N_POST*ROWS)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          i_start,
   input  logic                          i_abort,
   input  logic [2:0]                    i_mode,
   input  logic [5:0]                    i_ltp_shift,
   input  logic [4:0]                    i_ltd_shift,
   input  logic [N_POST-1:0]             i_post_spike,
   input  logic [ROWS*N_PRE-1:0]         i_pre_spike,
   input  logic [ROWS*N_PRE*T_BITS-1:0]  i_x_trace,
   input  logic [N_POST*T_BITS-1:0]      i_y1_trace,
   input  logic [N_POST*T_BITS-1:0]      i_y2_trace,
   output logic                          o_busy,
   output logic                          o_done,
   stdp_update_engine_if.master          ram
);
   localparam int P_W   = 2*T_BITS;
   localparam int SUM_W = W_BITS + 2*T_BITS + 2;
   localparam int NW    = (N_POST > 1) ? $clog2(N_POST) + 1 : 1;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(W_MIN);
   localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(W_MAX);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state, nxt;
   logic [NW-1:0]     neuron;
   logic [RW-1:0]     row;
   logic [1:0]        drain_cnt;
   logic [2:0]        mode_r;
   logic [5:0]        ltp_shift_r;
   logic [4:0]        ltd_shift_r;
   logic [ADDR_W-1:0] last_rd_addr, cur_addr;
   logic              issue, skip, last_n, last_r, abort_now;

   logic                     vld_p1, vld_p2, wr_en_q;
   logic [ADDR_W-1:0]        addr_p1, addr_p2, wr_addr_q;
   logic [T_BITS-1:0]        x_p1 [N_PRE];
   logic [N_PRE-1:0]         pre_p1;
   logic [T_BITS-1:0]        y2_p1, ltd_val_p1;
   logic                     ltp_en_p1, decay_p1, decay_p2;
   logic [W_BITS-1:0]        w_p2 [N_PRE];
   logic [P_W-1:0]           ltp_p2 [N_PRE];
   logic [T_BITS-1:0]        ltd_p2 [N_PRE];
   logic [N_PRE*W_BITS-1:0]  wr_word, wr_data_q;

   function automatic logic signed [SUM_W-1:0] lane_sum(input logic [W_BITS-1:0] w,
                                                        input logic [P_W-1:0]    ltp,
                                                        input logic [T_BITS-1:0] ltd,
                                                        input logic              dec);
      lane_sum = $signed(SUM_W'(w)) + $signed(SUM_W'(ltp))
               - $signed(SUM_W'(ltd)) - $signed(SUM_W'(dec));
   endfunction

   function automatic logic [W_BITS-1:0] clamp_w(input logic signed [SUM_W-1:0] s);
      if (s < MIN_S)      clamp_w = MIN_S[W_BITS-1:0];
      else if (s > MAX_S) clamp_w = MAX_S[W_BITS-1:0];
      else                clamp_w = s[W_BITS-1:0];
   endfunction

   assign cur_addr  = ADDR_W'(int'(neuron)*ROWS + int'(row));
   assign last_n    = (neuron == NW'(N_POST-1));
   assign last_r    = (row == RW'(ROWS-1));
   assign abort_now = i_abort && (state == RUN || state == DRAIN);
   // A neuron with neither a usable post spike nor any usable pre spike has no work; decay forces a visit.
   assign skip = (SKIP_IDLE != 0) && !mode_r[2] && (row == '0) &&
                 (!i_post_spike[neuron] || !mode_r[0]) && (!(|i_pre_spike) || !mode_r[1]);

   always_comb begin
      nxt   = state;
      issue = 1'b0;
      unique case (state)
         IDLE:  if (i_start) nxt = RUN;
         RUN: begin
            if (i_abort) nxt = IDLE;
            else begin
               issue = !skip;
               if (last_n && (skip || last_r)) nxt = DRAIN;
            end
         end
         DRAIN: if (i_abort) nxt = IDLE;
                else if (drain_cnt == 2'd2) nxt = DONE;
         DONE:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         neuron       <= '0;
         row          <= '0;
         drain_cnt    <= '0;
         mode_r       <= '0;
         ltp_shift_r  <= '0;
         ltd_shift_r  <= '0;
         last_rd_addr <= '0;
      end else begin
         state     <= nxt;
         drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
         if (state == IDLE && i_start) begin
            neuron      <= '0;
            row         <= '0;
            mode_r      <= i_mode;
            ltp_shift_r <= i_ltp_shift;
            ltd_shift_r <= i_ltd_shift;
         end else if (state == RUN && !i_abort) begin
            if (skip || last_r) begin
               row    <= '0;
               neuron <= neuron + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end
         if (issue) last_rd_addr <= cur_addr;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         vld_p1  <= issue;
         vld_p2  <= vld_p1 && !abort_now;
         wr_en_q <= vld_p2 && !abort_now;
         if (vld_p2 && !abort_now) begin
            wr_addr_q <= addr_p2;
            wr_data_q <= wr_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      // p1: operands for the issued word, captured alongside the RAM read
      if (issue) begin
         addr_p1    <= cur_addr;
         ltp_en_p1  <= mode_r[0] & i_post_spike[neuron];
         y2_p1      <= i_y2_trace[int'(neuron)*T_BITS +: T_BITS];
         ltd_val_p1 <= mode_r[1] ? (i_y1_trace[int'(neuron)*T_BITS +: T_BITS] >> ltd_shift_r) : '0;
         decay_p1   <= mode_r[2];
         for (int k = 0; k < N_PRE; k++) begin
            x_p1[k]   <= i_x_trace[(int'(row)*N_PRE + k)*T_BITS +: T_BITS];
            pre_p1[k] <= i_pre_spike[int'(row)*N_PRE + k];
         end
      end
      // p2: RAM word arrives, products formed
      if (vld_p1) begin
         addr_p2  <= addr_p1;
         decay_p2 <= decay_p1;
         for (int k = 0; k < N_PRE; k++) begin
            w_p2[k]   <= ram.rd_data[k*W_BITS +: W_BITS];
            ltp_p2[k] <= ltp_en_p1 ? ((P_W'(x_p1[k]) * P_W'(y2_p1)) >> ltp_shift_r) : '0;
            ltd_p2[k] <= pre_p1[k] ? ltd_val_p1 : '0;
         end
      end
   end

   // p3: sum and clamp into the write register
   always_comb begin
      wr_word = '0;
      for (int k = 0; k < N_PRE; k++)
         wr_word[k*W_BITS +: W_BITS] = clamp_w(lane_sum(w_p2[k], ltp_p2[k], ltd_p2[k], decay_p2));
   end

   assign ram.rd_en   = issue;
   assign ram.rd_addr = issue ? cur_addr : last_rd_addr;
   assign ram.wr_en   = wr_en_q;
   assign ram.wr_addr = wr_addr_q;
   assign ram.wr_data = wr_data_q;
   assign o_busy      = (state != IDLE);
   assign o_done      = (state == DONE);
endmodule
